// File: rtl/dmem_responder_if.sv
// Data-memory bus between a core (master) and the dmem_responder (slave).
// Carries one request at a time and its response.
//   req        core presents an access this cycle
//   we         1 = store, 0 = load
//   address    byte address
//   width      00 byte, 01 half, 10/11 word
//   usignext   1 = zero-extend loads, 0 = sign-extend loads
//   w_data     right-aligned store data
//   r_data     extended load data (registered in the responder)
//   stall      core must hold request inputs stable while high
//   misaligned access-fault indication, one cycle in the response
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] address;
  logic [1:0]  width;
  logic        usignext;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        stall;
  logic        misaligned;

  modport master (
    output req, we, address, width, usignext, w_data,
    input  r_data, stall, misaligned
  );

  modport slave (
    input  req, we, address, width, usignext, w_data,
    output r_data, stall, misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder. An access is latched in IDLE, waits
// LATENCY cycles in WAIT, is committed on the WAIT->RESP edge and the response
// (r_data / misaligned) is presented for the single RESP cycle.
// Ports:
//   clk    single clock
//   reset  synchronous, active-high reset
//   bus    dmem_responder_if.slave (request in, r_data/stall/misaligned out)
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses; otherwise misaligned is 0 and half/word addresses are forced to
// natural alignment.
module dmem_responder #(
  parameter int unsigned WORDS   = 16384,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW    = $clog2(WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept, commit;

  // Latched request
  logic          we_q;
  logic [IdxW+1:0] addr_q;
  logic [1:0]    width_q;
  logic          usignext_q;
  logic [31:0]   wdata_q;

  logic [31:0] r_data_q;
  logic        misaligned_q;

  logic [31:0] mem_q [WORDS];

  logic [31:0] word_rd, sh_byte, sh_half, load_val, wdata_lanes;
  logic [3:0]  be;
  logic        mis, mem_we;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      r_data_q     <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= commit && mis;
      if (commit) begin
        if (mis) begin
          r_data_q <= 32'd0;
        end else if (!we_q) begin
          r_data_q <= load_val;
        end
      end
    end
  end

  // Request is held stable by the core while stall is high, so one capture suffices.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= bus.we;
      addr_q     <= bus.address[IdxW+1:0];
      width_q    <= bus.width;
      usignext_q <= bus.usignext;
      wdata_q    <= bus.w_data;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = ((width_q == 2'b01) && addr_q[0]) ||
               (width_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Load path: shift the selected lane down to bit 0, then extend.
  assign word_rd = mem_q[addr_q[IdxW+1:2]];
  assign sh_byte = word_rd >> {addr_q[1:0], 3'b000};
  assign sh_half = word_rd >> {addr_q[1], 4'b0000};

  always_comb begin
    load_val = word_rd;
    unique case (width_q)
      2'b00:   load_val = {{24{!usignext_q && sh_byte[7]}}, sh_byte[7:0]};
      2'b01:   load_val = {{16{!usignext_q && sh_half[15]}}, sh_half[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // Store path: replicate data across lanes, enable only the addressed ones.
  always_comb begin
    wdata_lanes = wdata_q;
    be          = 4'b1111;
    unique case (width_q)
      2'b00: begin
        wdata_lanes = {4{wdata_q[7:0]}};
        be          = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wdata_lanes = {2{wdata_q[15:0]}};
        be          = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_lanes = wdata_q;
        be          = 4'b1111;
      end
    endcase
  end

  // Reset on the commit edge aborts the store.
  assign mem_we = commit && !reset && we_q && !mis;

  // Storage is deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[IdxW+1:2]][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign bus.stall      = !reset && (((state_q == StIdle) && bus.req) || (state_q == StWait));
  assign bus.r_data     = r_data_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a transaction-level memory model
// predicts stall/r_data/misaligned every cycle; literal checks pin the model.
module tb_dmem_responder;
  localparam int unsigned WORDS = 16384;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [int];
  logic        exp_stall = 1'b0;
  logic        exp_mis   = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  bit          check_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("stall",      {31'd0, bus.stall},      {31'd0, exp_stall});
      chk("r_data",     bus.r_data,              exp_rdata);
      chk("misaligned", {31'd0, bus.misaligned}, {31'd0, exp_mis});
    end
  end

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] w);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (w == 2'b01 && (a % 2) != 0) || (w >= 2'b10 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w,
                                             input bit us);
    logic [31:0] word, v;
    int off;
    word = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'd0;
    if (w == 2'b00) begin
      off = 8 * int'(a % 4);
      v = (word >> off) & 32'hFF;
      if (!us && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (w == 2'b01) begin
      off = 16 * int'((a % 4) / 2);
      v = (word >> off) & 32'hFFFF;
      if (!us && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    logic [31:0] word, mask;
    int off;
    word = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'd0;
    if (w == 2'b00) begin
      off  = 8 * int'(a % 4);
      mask = 32'hFF << off;
      word = (word & ~mask) | ((d & 32'hFF) << off);
    end else if (w == 2'b01) begin
      off  = 16 * int'((a % 4) / 2);
      mask = 32'hFFFF << off;
      word = (word & ~mask) | ((d & 32'hFFFF) << off);
    end else begin
      word = d;
    end
    mem_m[widx(a)] = word;
  endtask

  // Runs one access starting from IDLE; returns with the DUT in its RESP cycle.
  task automatic access(input bit w_e, input logic [31:0] a, input logic [1:0] wd,
                        input bit us, input logic [31:0] d, input bit hold, input bit drop);
    @(posedge clk); #1;
    exp_mis      = 1'b0;
    bus.req      = 1'b1;
    bus.we       = w_e;
    bus.address  = a;
    bus.width    = wd;
    bus.usignext = us;
    bus.w_data   = d;
    exp_stall    = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (drop) bus.req = 1'b0;
      exp_stall = 1'b1;
    end
    @(posedge clk); #1;
    exp_stall = 1'b0;
    if (is_mis(a, wd)) begin
      exp_mis   = 1'b1;
      exp_rdata = 32'd0;
    end else if (w_e) begin
      model_store(a, wd, d);
    end else begin
      exp_rdata = model_load(a, wd, us);
    end
    bus.req = hold;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_mis   = 1'b0;
      exp_stall = bus.req;
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.address = 32'd0; bus.width = 2'b10;
    bus.usignext = 1'b0; bus.w_data = 32'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_rdata", bus.r_data, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b0;
    idle(1);

    access(1, 32'h100, 2'b10, 0, 32'hDEADBEEF, 0, 0);
    chk("store_keeps_rdata", bus.r_data, 32'd0);
    access(0, 32'h100, 2'b10, 0, 32'd0, 0, 0);
    chk("load_word_100", bus.r_data, 32'hDEADBEEF);

    access(1, 32'h200, 2'b10, 0, 32'h00000000, 0, 0);
    access(1, 32'h201, 2'b00, 0, 32'h0000007F, 0, 0);
    access(0, 32'h200, 2'b10, 0, 32'd0, 0, 0);
    chk("load_word_200", bus.r_data, 32'h00007F00);
    access(0, 32'h201, 2'b00, 0, 32'd0, 0, 0);
    chk("load_byte_201", bus.r_data, 32'h0000007F);

    access(1, 32'h300, 2'b10, 0, 32'h8000F0A5, 0, 0);
    access(0, 32'h300, 2'b00, 0, 32'd0, 0, 0);
    chk("lb_300_sext", bus.r_data, 32'hFFFFFFA5);
    access(0, 32'h300, 2'b00, 1, 32'd0, 0, 0);
    chk("lb_300_zext", bus.r_data, 32'h000000A5);
    access(0, 32'h302, 2'b01, 0, 32'd0, 0, 0);
    chk("lh_302_sext", bus.r_data, 32'hFFFF8000);
    access(0, 32'h300, 2'b01, 0, 32'd0, 0, 0);
    access(0, 32'h303, 2'b00, 1, 32'd0, 0, 0);

    // Back-to-back with req held high through RESP
    access(0, 32'h100, 2'b10, 0, 32'd0, 1, 0);
    chk("b2b_first", bus.r_data, 32'hDEADBEEF);
    access(0, 32'h300, 2'b10, 0, 32'd0, 1, 0);
    chk("b2b_second", bus.r_data, 32'h8000F0A5);
    access(0, 32'h200, 2'b10, 0, 32'd0, 0, 0);
    chk("b2b_third", bus.r_data, 32'h00007F00);

    // req dropped during WAIT still completes
    access(0, 32'h300, 2'b11, 0, 32'd0, 0, 1);
    idle(1);
    // Upper address bits wrap onto the same word
    access(0, 32'h00010100, 2'b10, 0, 32'd0, 0, 0);
    chk("wrap_load", bus.r_data, 32'hDEADBEEF);

    access(1, 32'h202, 2'b01, 0, 32'h0000BEEF, 0, 0);
    access(0, 32'h200, 2'b10, 0, 32'd0, 0, 0);
    chk("half_store", bus.r_data, 32'hBEEF7F00);

    // Reset during WAIT aborts the store
    access(1, 32'h400, 2'b10, 0, 32'hCAFEF00D, 0, 0);
    @(posedge clk); #1;
    exp_mis = 1'b0;
    bus.req = 1'b1; bus.we = 1'b1; bus.address = 32'h400; bus.width = 2'b10;
    bus.w_data = 32'h11111111;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req = 1'b0;
    exp_rdata = 32'd0;
    chk("reset_wait_rdata", bus.r_data, 32'd0);
    idle(1);
    access(0, 32'h400, 2'b10, 0, 32'd0, 0, 0);
    chk("reset_wait_mem", bus.r_data, 32'hCAFEF00D);

    // Misaligned word store
    access(1, 32'h500, 2'b10, 0, 32'h55555555, 0, 0);
    access(1, 32'h502, 2'b10, 0, 32'h99999999, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, bus.misaligned}, 32'd1);
`else
    chk("mis_flag", {31'd0, bus.misaligned}, 32'd0);
`endif
    idle(1);
    access(0, 32'h500, 2'b10, 0, 32'd0, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_mem", bus.r_data, 32'h55555555);
`else
    chk("mis_mem", bus.r_data, 32'h99999999);
`endif

    idle(2);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WORDS, default 16384, number of 32-bit storage words (power of two).
REQ-002 Parameter LATENCY, default 2, wait cycles before response (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  core presents a data access this cycle.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 address  input  32  byte address; word index = address[log2(WORDS)+1:2], upper bits ignored (wrap).
REQ-008 width  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 usignext  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 w_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 r_data  output  32  extended load data, registered.
REQ-012 stall  output  1  core must hold all request inputs stable while high.
REQ-013 misaligned  output  1  access-fault indication (see Configuration).

Function
REQ-014 FSM states IDLE, WAIT, RESP; 4-bit down-counter cnt.
REQ-015 IDLE with req=1 at posedge: latch request, cnt <= LATENCY-1, go WAIT; req=0: stay IDLE.
REQ-016 WAIT: cnt != 0 -> decrement; cnt == 0 -> go RESP, commit store / capture load on that edge.
REQ-017 RESP: one cycle, always -> IDLE; next request accepted from IDLE only.
REQ-018 stall = (IDLE and req) or WAIT; stall high exactly LATENCY+1 cycles per access, low in RESP.
REQ-019 Store: byte writes lane address[1:0]; half writes lanes {address[1],0} and +1; word writes all 4; other lanes unchanged.
REQ-020 Load: selected byte/half shifted to bit 0, extended to 32 bits per usignext; word unchanged; r_data updates only on WAIT->RESP edge, holds otherwise.
REQ-021 Stores leave r_data unchanged.
REQ-022 req dropping during WAIT does not abort; access completes using latched values.
REQ-023 Storage contents are not initialized or cleared by reset.

Reset
REQ-024 reset high: state <= IDLE, cnt <= 0, r_data <= 0, misaligned <= 0.
REQ-025 stall forced 0 while reset high.
REQ-026 Reset during WAIT aborts the access: no store committed, r_data stays 0.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN.
REQ-028 Defined: half with address[0]=1 or word with address[1:0]!=0 is misaligned; on WAIT->RESP no store, r_data <= 0, misaligned high for the RESP cycle only.
REQ-029 Not defined: misaligned tied 0; half ignores address[0], word ignores address[1:0] (forced alignment).

Verification
REQ-030 LATENCY=2: store word 0xDEADBEEF @0x100, load word @0x100 -> stall high 3 cycles each, r_data=0xDEADBEEF in RESP cycle.
REQ-031 Store byte 0x7F @0x201 over word 0x00000000, load word @0x200 -> 0x00007F00; load byte @0x201 usignext=0 -> 0x0000007F.
REQ-032 Word 0x8000F0A5 @0x300: load byte @0x300 usignext=0 -> 0xFFFFFFA5; usignext=1 -> 0x000000A5; load half @0x302 usignext=0 -> 0xFFFF8000.
REQ-033 Back-to-back loads with req held high -> RESP, one IDLE cycle with stall high, new access; each returns correct data.
REQ-034 Store 0x11111111 @0x400, assert reset one cycle in WAIT -> stall low in reset, later load @0x400 returns prior contents.
REQ-035 With DMEM_MISALIGN_TRAP_EN: store word @0x502 -> misaligned=1 one cycle, memory unchanged; without macro: same store writes word @0x500.
